hex_display_scanner: RTL

Time-multiplexed driver for a bank of common-anode seven-segment digits, generalising the single-digit hex decoder to NUM_DIGITS digits. It holds a frame of hex nibbles, per-digit blanking and decimal points, then scans them one digit at a time with a programmable slot length and an anti-ghosting blank interval. New frames are double-buffered and commit only on a frame boundary, so the display never tears. It sits between the board-level display pins and any logic that produces a hex value for display.

---
 rtl/hex_display_pkg.sv | 39 +++
 rtl/hex_seg_lut.sv | 17 +
 rtl/hex_display_scanner.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_pkg
// Description : Shared constants and helpers for the hex seven-segment
//               display scanner: active-low segment table and decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_display_pkg;

    // Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry n holds the pattern for hex digit n (entry 15 listed first).
    localparam logic [15:0][6:0] c_SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Decode one hex nibble into its active-low segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] i_nibble);
        return c_SEG_TABLE[i_nibble];
    endfunction

endpackage : hex_display_pkg
`default_nettype wire

// File: rtl/hex_seg_lut.sv
`default_nettype none
// ============================================================================
// Module      : hex_seg_lut
// Description : Combinational 4-bit hex to 7-segment (active-low) decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_seg_lut
    import hex_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_nibble);

endmodule : hex_seg_lut
`default_nettype wire

// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_scanner
// Description : Time-multiplexed common-anode seven-segment driver for
//               NUM_DIGITS hex digits with per-digit blanking, decimal
//               points, leading-zero blanking, anti-ghosting blank interval
//               and double-buffered frames committed on frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    lzb,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W = $clog2(NUM_DIGITS);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_wrapped;   // the previous cycle closed a frame

    // ------------------------------------------------------------------
    // Pending and active frame buffers
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] r_pend_value;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_lzb;
    logic                    r_pend_valid;

    logic [4*NUM_DIGITS-1:0] r_act_value;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic                    r_act_lzb;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic                  w_in_blank;
    logic [NUM_DIGITS-1:0] w_nz_from;   // bit i: some nibble at i or above is non-zero
    logic [NUM_DIGITS-1:0] w_off;       // bit i: digit i shows nothing
    logic [3:0]            w_cur_nib;
    logic                  w_cur_off;
    logic                  w_cur_dp;
    logic [6:0]            w_lut_seg;

    assign w_slot_end  = (r_cnt == c_CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);

    // Anodes stay off for the first BLANK_CYCLES of each slot so the
    // previous digit's segments never bleed into the next one.
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign w_in_blank = 1'b0;
    end else begin : g_blank
        assign w_in_blank = (r_cnt < c_CNT_W'(BLANK_CYCLES));
    end

    // Zero-scan from the most significant digit downwards; a digit is a
    // leading zero when it and everything above it are zero. Digit 0 is
    // always kept so a zero value still shows "0".
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        if (gi == NUM_DIGITS - 1) begin : g_msb
            assign w_nz_from[gi] = |r_act_value[4*gi +: 4];
        end else begin : g_lower
            assign w_nz_from[gi] = (|r_act_value[4*gi +: 4]) | w_nz_from[gi+1];
        end

        if (gi == 0) begin : g_lsd
            assign w_off[gi] = r_act_blank[gi];
        end else begin : g_upper
            assign w_off[gi] = r_act_blank[gi] | (r_act_lzb & ~w_nz_from[gi]);
        end
    end

    // Select the digit currently being scanned; one decoder serves all.
    assign w_cur_nib = 4'(r_act_value >> {r_idx, 2'b00});
    assign w_cur_off = w_off[r_idx];
    assign w_cur_dp  = r_act_dp[r_idx];

    hex_seg_lut u_seg_lut (
        .i_nibble (w_cur_nib),
        .o_seg    (w_lut_seg)
    );

    // Slot counter and digit index advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_wrapped <= 1'b0;
        end else begin
            r_wrapped <= w_frame_end;
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Pending buffer: the latest load wins until the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_value <= '0;
            r_pend_blank <= '0;
            r_pend_dp    <= '0;
            r_pend_lzb   <= 1'b0;
            r_pend_valid <= 1'b0;
        end else if (w_frame_end) begin
            // Any pending frame (or a same-cycle load) is consumed now.
            r_pend_valid <= 1'b0;
        end else if (load) begin
            r_pend_value <= value;
            r_pend_blank <= blank;
            r_pend_dp    <= dp;
            r_pend_lzb   <= lzb;
            r_pend_valid <= 1'b1;
        end
    end

    // Active buffer: updated only on the last cycle of a frame, so a frame
    // is never shown half old and half new. A load arriving in that very
    // cycle bypasses the pending buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_value <= '0;
            r_act_blank <= '1;
            r_act_dp    <= '0;
            r_act_lzb   <= 1'b0;
        end else if (w_frame_end) begin
            if (load) begin
                r_act_value <= value;
                r_act_blank <= blank;
                r_act_dp    <= dp;
                r_act_lzb   <= lzb;
            end else if (r_pend_valid) begin
                r_act_value <= r_pend_value;
                r_act_blank <= r_pend_blank;
                r_act_dp    <= r_pend_dp;
                r_act_lzb   <= r_pend_lzb;
            end
        end
    end

    // Registered display outputs, one cycle behind the scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= w_cur_off ? SEG_BLANK : w_lut_seg;
            dp_n       <= ~(w_cur_dp & ~w_cur_off);
            an_n       <= w_in_blank ? '1 : ~(NUM_DIGITS'(1) << r_idx);
            frame_done <= r_wrapped;
        end
    end

endmodule : hex_display_scanner
`default_nettype wire
